// File: rtl/mem_ctrl_pkg.sv
// Shared widths, requester source ids and the command record layout
// for the memory-controller command path.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] SRC_R1 = 2'd0;
  localparam logic [1:0] SRC_R2 = 2'd1;
  localparam logic [1:0] SRC_R3 = 2'd2;

  // Field order matches the packed FIFO word, MSB first.
  typedef struct packed {
    logic [1:0]            src;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguished without an occupancy counter.
module mem_cmd_fifo #(
  parameter int WIDTH = 51,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mem_cmd_issue.sv
// Captures one command per grant assertion from three requesters into a
// FIFO and issues the queued commands to memory over valid/ready.
module mem_cmd_issue
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant1,
  input  logic              grant2,
  input  logic              grant3,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic              we1,
  input  logic              we2,
  input  logic              we3,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [DATA_W-1:0] wdata3,
  output logic              ack1,
  output logic              ack2,
  output logic              ack3,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_src,
  output logic              full,
  output logic              grant_err
);

  localparam int CMD_W = 2 + 1 + ADDR_W + DATA_W;

  logic [2:0]       grant;
  logic [2:0]       elig;
  logic [2:0]       sel_oh;
  logic [2:0]       arm_q, arm_d;
  logic [2:0]       ack_q, ack_d;
  logic             grant_err_q, grant_err_d;
  logic [1:0]       sel_src;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [CMD_W-1:0] push_data;
  logic [CMD_W-1:0] head;

  assign grant  = {grant3, grant2, grant1};
  assign elig   = grant & arm_q;
  // Lowest-index eligible requester wins.
  assign sel_oh = elig & (~elig + 3'd1);

  always_comb begin
    sel_src     = SRC_R1;
    push_data   = {SRC_R1, we1, addr1, wdata1};
    push        = (elig != 3'd0) && !full;
    ack_d       = push ? sel_oh : 3'd0;
    // A low grant re-arms; a capture disarms until the grant drops.
    arm_d       = ~grant | (arm_q & ~ack_d);
    grant_err_d = grant_err_q | ((grant & (grant - 3'd1)) != 3'd0);
    if (sel_oh[1]) begin
      sel_src   = SRC_R2;
      push_data = {SRC_R2, we2, addr2, wdata2};
    end else if (sel_oh[2]) begin
      sel_src   = SRC_R3;
      push_data = {SRC_R3, we3, addr3, wdata3};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_q       <= 3'b111;
      ack_q       <= 3'b000;
      grant_err_q <= 1'b0;
    end else begin
      arm_q       <= arm_d;
      ack_q       <= ack_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign pop = mem_valid & mem_ready;

  mem_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (fifo_empty)
  );

  assign mem_valid = ~fifo_empty;
  assign {mem_src, mem_we, mem_addr, mem_wdata} = head;
  assign {ack3, ack2, ack1} = ack_q;
  assign grant_err = grant_err_q;

  logic unused_sel;
  assign unused_sel = ^sel_src;

endmodule

// File: tb/tb_mem_cmd_issue.sv
// Bench for mem_cmd_issue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_cmd_issue;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          grant1, grant2, grant3;
  logic [AW-1:0] addr1, addr2, addr3;
  logic          we1, we2, we3;
  logic [DW-1:0] wdata1, wdata2, wdata3;
  logic          ack1, ack2, ack3;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_src;
  logic          full, grant_err;

  int errs   = 0;
  int checks = 0;

  mem_cmd_issue #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .grant1(grant1), .grant2(grant2), .grant3(grant3),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .we1(we1), .we2(we2), .we3(we3),
    .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_src(mem_src), .full(full), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of commands plus per-requester arm flags.
  typedef struct {
    logic [1:0]    src;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t q[$];
  bit   arm[3] = '{1'b1, 1'b1, 1'b1};
  bit   gerr   = 1'b0;
  bit [2:0] eack = 3'b000;

  function automatic cmd_t cmd_of(int n);
    cmd_t c;
    case (n)
      0:       c = '{2'd0, we1, addr1, wdata1};
      1:       c = '{2'd1, we2, addr2, wdata2};
      default: c = '{2'd2, we3, addr3, wdata3};
    endcase
    return c;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit [2:0] g;
    int cap;
    int ng;
    if (reset) begin
      q.delete();
      arm  = '{1'b1, 1'b1, 1'b1};
      gerr = 1'b0;
      eack = 3'b000;
    end else begin
      g  = {grant3, grant2, grant1};
      ng = int'(g[0]) + int'(g[1]) + int'(g[2]);
      if (ng > 1) gerr = 1'b1;
      cap = -1;
      if (q.size() < DEPTH)
        for (int n = 0; n < 3; n++)
          if (cap < 0 && g[n] && arm[n]) cap = n;
      if (q.size() > 0 && mem_ready) void'(q.pop_front());
      if (cap >= 0) q.push_back(cmd_of(cap));
      eack = 3'b000;
      for (int n = 0; n < 3; n++) begin
        if (!g[n]) arm[n] = 1'b1;
        else if (n == cap) arm[n] = 1'b0;
      end
      if (cap >= 0) eack[cap] = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("ack1", 32'(ack1), 32'(eack[0]));
    chk("ack2", 32'(ack2), 32'(eack[1]));
    chk("ack3", 32'(ack3), 32'(eack[2]));
    chk("mem_valid", 32'(mem_valid), 32'(q.size() > 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("grant_err", 32'(grant_err), 32'(gerr));
    if (q.size() > 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
      chk("mem_we", 32'(mem_we), 32'(q[0].we));
      chk("mem_wdata", mem_wdata, q[0].wdata);
      chk("mem_src", 32'(mem_src), 32'(q[0].src));
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  int acks;
  int pr;

  initial begin
    reset = 1'b1;
    {grant1, grant2, grant3} = 3'b000;
    {we1, we2, we3} = 3'b000;
    addr1 = '0; addr2 = '0; addr3 = '0;
    wdata1 = '0; wdata2 = '0; wdata3 = '0;
    mem_ready = 1'b0;
    repeat (2) nxt();
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(grant_err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_ack", 32'({ack3, ack2, ack1}), 32'd0);
    reset = 1'b0;
    nxt();

    // single capture and issue
    mem_ready = 1'b1;
    addr1 = 16'h0040; we1 = 1'b1; wdata1 = 32'hDEADBEEF; grant1 = 1'b1;
    nxt();
    chk("t1_ack1", 32'(ack1), 32'd1);
    chk("t1_valid", 32'(mem_valid), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'h0040);
    chk("t1_src", 32'(mem_src), 32'd0);
    chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
    grant1 = 1'b0;
    nxt();
    chk("t1_ack1_once", 32'(ack1), 32'd0);
    chk("t1_drained", 32'(mem_valid), 32'd0);

    // long grant yields one capture
    mem_ready = 1'b0;
    addr2 = 16'h0222; we2 = 1'b0; grant2 = 1'b1;
    acks = 0;
    repeat (20) begin nxt(); acks += int'(ack2); end
    chk("t2_acks", 32'(acks), 32'd1);
    chk("t2_full", 32'(full), 32'd0);
    grant2 = 1'b0;
    nxt();
    grant2 = 1'b1; addr2 = 16'h0333;
    nxt();
    chk("t2_reack", 32'(ack2), 32'd1);
    chk("t2_head", 32'(mem_addr), 32'h0222);
    grant2 = 1'b0; mem_ready = 1'b1;
    repeat (4) nxt();
    chk("t2_drained", 32'(mem_valid), 32'd0);

    // fill, stall, then one slot frees
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr3 = 16'h3000 + 16'(i); grant3 = 1'b1;
      nxt();
      grant3 = 1'b0;
      nxt();
    end
    chk("t3_full", 32'(full), 32'd1);
    addr3 = 16'h3FFF; grant3 = 1'b1;
    acks = 0;
    repeat (5) begin nxt(); acks += int'(ack3); end
    chk("t3_stall", 32'(acks), 32'd0);
    mem_ready = 1'b1;
    nxt();
    mem_ready = 1'b0;
    chk("t3_no_ack_on_pop", 32'(ack3), 32'd0);
    nxt();
    chk("t3_ack_after_pop", 32'(ack3), 32'd1);
    chk("t3_refull", 32'(full), 32'd1);
    chk("t3_head", 32'(mem_addr), 32'h3001);
    grant3 = 1'b0; mem_ready = 1'b1;
    repeat (6) nxt();
    chk("t3_drained", 32'(mem_valid), 32'd0);

    // simultaneous push and pop
    mem_ready = 1'b0;
    grant2 = 1'b1; addr2 = 16'h0100; nxt();
    grant2 = 1'b0; nxt();
    grant2 = 1'b1; addr2 = 16'h0200; nxt();
    grant2 = 1'b0; nxt();
    grant1 = 1'b1; addr1 = 16'h0300; mem_ready = 1'b1;
    nxt();
    grant1 = 1'b0; mem_ready = 1'b0;
    chk("t4_step", 32'(mem_addr), 32'h0200);
    chk("t4_ack1", 32'(ack1), 32'd1);
    chk("t4_notfull", 32'(full), 32'd0);
    mem_ready = 1'b1;
    nxt();
    chk("t4_order", 32'(mem_addr), 32'h0300);
    nxt();
    chk("t4_occ2", 32'(mem_valid), 32'd0);
    mem_ready = 1'b0;

    // two grants in one cycle
    addr1 = 16'h0510; addr3 = 16'h0530; grant1 = 1'b1; grant3 = 1'b1;
    nxt();
    chk("t5_ack1", 32'(ack1), 32'd1);
    chk("t5_ack3_wait", 32'(ack3), 32'd0);
    chk("t5_err", 32'(grant_err), 32'd1);
    chk("t5_head", 32'(mem_addr), 32'h0510);
    grant1 = 1'b0;
    nxt();
    chk("t5_ack3", 32'(ack3), 32'd1);
    grant3 = 1'b0;
    nxt();
    chk("t5_sticky", 32'(grant_err), 32'd1);
    mem_ready = 1'b1;
    repeat (3) nxt();
    mem_ready = 1'b0;

    // async reset with entries queued
    for (int i = 0; i < 3; i++) begin
      grant1 = 1'b1; addr1 = 16'h0600 + 16'(i); nxt();
      grant1 = 1'b0; nxt();
    end
    chk("t6_pre_valid", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(mem_valid), 32'd0);
    chk("t6_async_err", 32'(grant_err), 32'd0);
    nxt();
    reset = 1'b0;
    nxt();
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_empty", 32'(mem_valid), 32'd0);
    chk("t6_err", 32'(grant_err), 32'd0);

    // randomized traffic with varying back-pressure
    pr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) pr = int'($urandom_range(5, 95));
      if ($urandom_range(0, 3) == 0) grant1 = ~grant1;
      if ($urandom_range(0, 3) == 0) grant2 = ~grant2;
      if ($urandom_range(0, 4) == 0) grant3 = ~grant3;
      mem_ready = (int'($urandom_range(0, 99)) < pr);
      addr1 = 16'($urandom); addr2 = 16'($urandom); addr3 = 16'($urandom);
      wdata1 = $urandom; wdata2 = $urandom; wdata3 = $urandom;
      we1 = 1'($urandom); we2 = 1'($urandom); we3 = 1'($urandom);
      reset = ($urandom_range(0, 599) == 0);
      nxt();
    end
    reset = 1'b0;
    nxt();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
